// File: rtl/freq_mult_pkg.sv
// Shared types and constants for the clock-multiplier calibration sequencer.
// The divider value is derived from one measured period of the slow clock.
package freq_mult_pkg;

  localparam int MEAS_W = 16;
  localparam int K_W    = 8;

  localparam logic [K_W-1:0]    K_MAX        = 8'd255;
  localparam logic [MEAS_W-1:0] MEAS_TIMEOUT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    MEASURE = 3'd2,
    CALC    = 3'd3,
    LOAD    = 3'd4,
    RUN     = 3'd5
  } state_e;

  typedef struct packed {
    logic [K_W-1:0] k;
    logic           err;
    logic           abort;
  } calc_t;

  // Divider value for a measured period: half-period of the multiplied clock
  // expressed in reference cycles, saturated to the counter range.
  function automatic calc_t calc_k(input logic [MEAS_W-1:0] period,
                                   input logic [2:0]        exp_n,
                                   input logic [K_W-1:0]    k_prev);
    calc_t             res;
    logic [MEAS_W-1:0] q;
    q         = period >> ({1'b0, exp_n} + 4'd1);
    res.k     = k_prev;
    res.err   = 1'b0;
    res.abort = 1'b0;
    if (q == '0) begin
      res.err   = 1'b1;
      res.abort = 1'b1;
    end else if (|q[MEAS_W-1:K_W]) begin
      res.k   = K_MAX;
      res.err = 1'b1;
    end else begin
      res.k = q[K_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_mult_sequencer_edge_sync.sv
// Two-flop synchronizer for the asynchronous measured clock followed by a
// registered rising-edge detector; rise pulses for one cycle.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_mult_sequencer.sv
// Calibration sequencer: measures one period of f in reference cycles, derives
// the output divider reload value k for f * 2^n and then runs the divider.
module freq_mult_sequencer
  import freq_mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           f,
  input  logic           adjust,
  input  logic [2:0]     n,
  input  logic           cout,
  output logic           ld_cnt,
  output logic           cnt_en,
  output logic [K_W-1:0] k,
  output logic           valid,
  output logic           busy,
  output logic           err
);

  state_e            state_q, state_d;
  logic [MEAS_W-1:0] meas_q, meas_d;
  logic [MEAS_W-1:0] period_q, period_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              err_q, err_d;
  logic              rise;
  calc_t             calc_res;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (f),
    .rise (rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      meas_q   <= '0;
      period_q <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      meas_q   <= meas_d;
      period_q <= period_d;
      k_q      <= k_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    meas_d   = meas_q;
    period_d = period_q;
    k_d      = k_q;
    err_d    = err_q;
    calc_res = calc_k(period_q, n, k_q);

    // A fresh request always wins, whatever the sequencer is doing.
    if (adjust) begin
      state_d = SYNC;
      meas_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SYNC: begin
          if (meas_q == MEAS_TIMEOUT) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (rise) begin
            state_d = MEASURE;
            meas_d  = '0;
          end else begin
            meas_d = meas_q + MEAS_W'(1);
          end
        end
        MEASURE: begin
          // Timeout is checked first so meas never wraps and P fits MEAS_W.
          if (meas_q == MEAS_TIMEOUT) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (rise) begin
            state_d  = CALC;
            period_d = meas_q + MEAS_W'(1);
          end else begin
            meas_d = meas_q + MEAS_W'(1);
          end
        end
        CALC: begin
          k_d     = calc_res.k;
          err_d   = err_q | calc_res.err;
          state_d = calc_res.abort ? IDLE : LOAD;
        end
        LOAD: begin
          state_d = RUN;
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q == SYNC) || (state_q == MEASURE) ||
                  (state_q == CALC) || (state_q == LOAD);
  assign valid  = (state_q == RUN);
  assign cnt_en = (state_q == RUN);
  assign ld_cnt = (state_q == LOAD) || ((state_q == RUN) && cout);
  assign k      = k_q;
  assign err    = err_q;

endmodule

// File: tb/tb_freq_mult_sequencer.sv
// Randomized scoreboard bench for freq_mult_sequencer: each calibration's
// expected outcome is queued at stimulus time and checked when busy drops.
`timescale 1ns/1ps
module tb_freq_mult_sequencer;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       f      = 1'b0;
  logic       adjust = 1'b0;
  logic [2:0] n      = 3'd0;
  logic       cout   = 1'b0;
  logic       ld_cnt, cnt_en, valid, busy, err;
  logic [7:0] k;

  typedef struct {
    int k;
    int err;
    int valid;
    int ld_n;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;
  int   model_k  = 0;

  freq_mult_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .f      (f),
    .adjust (adjust),
    .n      (n),
    .cout   (cout),
    .ld_cnt (ld_cnt),
    .cnt_en (cnt_en),
    .k      (k),
    .valid  (valid),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per completed calibration (busy falling).
  initial begin : monitor
    logic busy_prev;
    int   ld_seen;
    exp_t e;
    busy_prev = 1'b0;
    ld_seen   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
        ld_seen   = 0;
      end else begin
        if (busy && !busy_prev) ld_seen = 0;
        if (busy && ld_cnt) ld_seen++;
        if (!busy && busy_prev) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got calibration end, expected none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            $display("[TB] cal done cycle %0d: k=%0d err=%0d valid=%0d (exp k=%0d err=%0d valid=%0d)",
                     cyc, k, err, valid, e.k, e.err, e.valid);
            chk("done_k", int'(k), e.k);
            chk("done_err", int'(err), e.err);
            chk("done_valid", int'(valid), e.valid);
            chk("done_cnt_en", int'(cnt_en), e.valid);
            chk("load_pulses", ld_seen, e.ld_n);
            chk("done_cycle", cyc, e.done_cyc);
          end
          done_cnt++;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic wait_done(input int budget, input string name);
    int w;
    w = 0;
    while (done_cnt < push_cnt && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt < push_cnt) begin
      tests++;
      fails++;
      $display("FAIL %s: got busy still high after %0d cycles, expected calibration end", name, budget);
      sb.delete();
      push_cnt = done_cnt;
    end
  endtask

  task automatic adjust_pulse(input logic [2:0] nn, input bit with_cout);
    @(negedge clk);
    adjust = 1'b1;
    cout   = with_cout;
    n      = nn;
    @(negedge clk);
    adjust = 1'b0;
    cout   = 1'b0;
    chk("adj_busy", int'(busy), 1);
    chk("adj_valid", int'(valid), 0);
    chk("adj_err_clear", int'(err), 0);
    chk("adj_no_load", int'(ld_cnt), 0);
  endtask

  // Two rising edges of f exactly 'period' reference cycles apart.
  task automatic measure(input int period, input logic [2:0] nn);
    exp_t e;
    int   c;
    int   q;
    repeat ($urandom_range(4, 1)) @(negedge clk);
    @(posedge clk);
    #3;
    f = 1'b1;
    repeat (period / 2) @(posedge clk);
    #3;
    f = 1'b0;
    repeat (period - period / 2) @(posedge clk);
    #3;
    f = 1'b1;
    c = cyc;
    q = period / (2 ** (int'(nn) + 1));
    e.valid    = (q != 0) ? 1 : 0;
    e.err      = (q == 0 || q > 255) ? 1 : 0;
    e.k        = (q == 0) ? model_k : ((q > 255) ? 255 : q);
    e.ld_n     = e.valid;
    e.done_cyc = c + ((q == 0) ? 5 : 6);
    model_k    = e.k;
    sb.push_back(e);
    push_cnt++;
    repeat (2) @(posedge clk);
    #3;
    f = 1'b0;
    wait_done(100, "cal_done");
  endtask

  task automatic run_cal(input int period, input logic [2:0] nn, input bit with_cout);
    adjust_pulse(nn, with_cout);
    measure(period, nn);
  endtask

  initial begin : stim
    exp_t e;
    int   p;
    int   activity;
    logic [2:0] nn;

    repeat (3) @(negedge clk);
    chk("rst_ld_cnt", int'(ld_cnt), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_k", int'(k), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_without_adjust", int'(busy), 0);

    run_cal(50, 3'd2, 1'b0);

    @(negedge clk);
    cout = 1'b1;
    #1;
    chk("cout_ld_cnt", int'(ld_cnt), 1);
    chk("cout_cnt_en", int'(cnt_en), 1);
    chk("run_k", int'(k), 6);
    @(negedge clk);
    cout = 1'b0;
    #1;
    chk("cout_ld_released", int'(ld_cnt), 0);
    chk("cout_valid_hold", int'(valid), 1);

    run_cal(50, 3'd0, 1'b0);
    run_cal(50, 3'd7, 1'b0);
    run_cal(1000, 3'd0, 1'b0);
    run_cal(64, 3'd1, 1'b1);

    // Restart while measuring: the first edge is discarded.
    adjust_pulse(3'd1, 1'b0);
    @(posedge clk);
    #3;
    f = 1'b1;
    repeat (10) @(posedge clk);
    adjust_pulse(3'd1, 1'b0);
    f = 1'b0;
    repeat (4) @(negedge clk);
    measure(120, 3'd1);

    for (int i = 0; i < 16; i++) begin
      p  = $urandom_range(300, 4);
      nn = 3'($urandom_range(7, 0));
      run_cal(p, nn, 1'($urandom_range(1, 0)));
    end

    // f stuck low: measurement must time out.
    @(negedge clk);
    adjust     = 1'b1;
    n          = 3'd3;
    e.k        = model_k;
    e.err      = 1;
    e.valid    = 0;
    e.ld_n     = 0;
    e.done_cyc = cyc + 1 + 65536;
    sb.push_back(e);
    push_cnt++;
    @(negedge clk);
    adjust = 1'b0;
    wait_done(70000, "timeout_done");
    run_cal(40, 3'd1, 1'b0);

    // Asynchronous reset in the middle of MEASURE.
    adjust_pulse(3'd0, 1'b0);
    @(posedge clk);
    #3;
    f = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ld_cnt", int'(ld_cnt), 0);
    chk("arst_cnt_en", int'(cnt_en), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_k", int'(k), 0);
    model_k = 0;
    @(negedge clk);
    f = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    activity = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 10 || i == 40) f = 1'b1;
      if (i == 30 || i == 50) f = 1'b0;
      activity = activity | int'(busy | valid | ld_cnt | cnt_en | err);
    end
    chk("idle_after_reset", activity, 0);

    run_cal(50, 3'd7, 1'b0);
    run_cal(50, 3'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
